// File: rtl/issue_ctrl.sv
// issue_ctrl: single-entry issue register between decode and execute.
// A 32-bit pending-write scoreboard blocks RAW/WAW hazards, the number of
// outstanding register writers is bounded by MAX_INFLIGHT, and a flush
// discards the issue register together with all scoreboard state.
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic        dec_wr_rd,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [4:0]  iss_rs1,
  output logic [4:0]  iss_rs2,
  output logic [4:0]  iss_rd,
  output logic        iss_wr_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [31:0] pending,
  output logic [3:0]  inflight
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [3:0]  inflight_q, inflight_d;
  logic [4:0]  issRs1_q, issRs1_d;
  logic [4:0]  issRs2_q, issRs2_d;
  logic [4:0]  issRd_q, issRd_d;
  logic        issWrRd_q, issWrRd_d;

  logic hazard;
  logic atLimit;
  logic accept;
  logic wbHit;
  logic setPend;

  // Hazard and writer-limit detection use only the registered scoreboard, so a
  // writeback in the same cycle never unblocks the decode instruction.
  always_comb begin
    hazard  = (dec_use_rs1 && (dec_rs1 != 5'd0) && pending_q[dec_rs1])
            | (dec_use_rs2 && (dec_rs2 != 5'd0) && pending_q[dec_rs2])
            | (dec_wr_rd   && (dec_rd  != 5'd0) && pending_q[dec_rd]);
    atLimit = dec_wr_rd && (dec_rd != 5'd0) && (inflight_q == 4'(MAX_INFLIGHT));
    dec_ready = !flush && ((state_q == EMPTY) || iss_ready) && !hazard && !atLimit;
    accept  = dec_valid && dec_ready;
    wbHit   = wb_valid && (wb_rd != 5'd0) && pending_q[wb_rd];
    setPend = accept && dec_wr_rd && (dec_rd != 5'd0);
  end

  // Issue FSM next state: fill on accept, drain when execute takes with no refill.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = FULL;
        FULL:    if (iss_ready && !accept) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Scoreboard, writer count and issue-register next values; flush wins over all.
  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
    issRs1_d   = issRs1_q;
    issRs2_d   = issRs2_q;
    issRd_d    = issRd_q;
    issWrRd_d  = issWrRd_q;
    if (flush) begin
      pending_d  = 32'd0;
      inflight_d = 4'd0;
    end else begin
      if (wbHit) pending_d[wb_rd] = 1'b0;
      if (setPend) pending_d[dec_rd] = 1'b1;
      if (setPend && !wbHit) inflight_d = inflight_q + 4'd1;
      else if (wbHit && !setPend) inflight_d = inflight_q - 4'd1;
      if (accept) begin
        issRs1_d  = dec_rs1;
        issRs2_d  = dec_rs2;
        issRd_d   = dec_rd;
        issWrRd_d = dec_wr_rd;
      end
    end
    pending_d[0] = 1'b0;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      pending_q  <= 32'd0;
      inflight_q <= 4'd0;
      issRs1_q   <= 5'd0;
      issRs2_q   <= 5'd0;
      issRd_q    <= 5'd0;
      issWrRd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      issRs1_q   <= issRs1_d;
      issRs2_q   <= issRs2_d;
      issRd_q    <= issRd_d;
      issWrRd_q  <= issWrRd_d;
    end
  end

  assign iss_valid = (state_q == FULL);
  assign iss_rs1   = issRs1_q;
  assign iss_rs2   = issRs2_q;
  assign iss_rd    = issRd_q;
  assign iss_wr_rd = issWrRd_q;
  assign pending   = pending_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed and randomized checks of issue_ctrl against a
// scoreboard model holding the set of outstanding destination registers.
module tb_issue_ctrl;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_wr_rd;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_wr_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] pending;
  logic [3:0]  inflight;

  int checks = 0;
  int errors = 0;

  // Model: set of registers with an outstanding write, plus the issue slot.
  bit         mPend[32];
  bit         mValid;
  logic [4:0] mRs1, mRs2, mRd;
  logic       mWr;

  issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wr_rd(iss_wr_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending(pending), .inflight(inflight)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic int pendCount();
    int n = 0;
    for (int i = 1; i < 32; i++) if (mPend[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] pendVec();
    logic [31:0] v = 32'd0;
    for (int i = 1; i < 32; i++) v[i] = mPend[i];
    return v;
  endfunction

  function automatic bit modelReady();
    bit hz;
    hz = (dec_use_rs1 && dec_rs1 != 0 && mPend[dec_rs1])
      || (dec_use_rs2 && dec_rs2 != 0 && mPend[dec_rs2])
      || (dec_wr_rd && dec_rd != 0 && mPend[dec_rd]);
    return !flush && (!mValid || iss_ready) && !hz
        && !(dec_wr_rd && dec_rd != 0 && pendCount() == MAXI);
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    mValid = 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit dv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input bit u1, input bit u2, input bit wr,
                               input bit ir, input bit wbv, input logic [4:0] wbr, input bit fl);
    dec_valid = dv; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr;
    iss_ready = ir; wb_valid = wbv; wb_rd = wbr; flush = fl;
  endtask

  // One clock: check dec_ready before the edge, advance the model, check state after.
  task automatic cycle(input string tag, input int expReadyConst = -1);
    bit expReady, acc, wbHit, inc;
    #2;
    expReady = modelReady();
    checkOutput({tag, ".ready"}, {31'd0, dec_ready}, {31'd0, expReady});
    if (expReadyConst >= 0)
      checkOutput({tag, ".readyConst"}, {31'd0, dec_ready}, expReadyConst[31:0]);
    acc   = dec_valid && expReady;
    wbHit = wb_valid && wb_rd != 0 && mPend[wb_rd];
    inc   = acc && dec_wr_rd && dec_rd != 0;
    @(posedge clk);
    if (flush) begin
      modelClear();
    end else begin
      if (wbHit) mPend[wb_rd] = 1'b0;
      if (inc) mPend[dec_rd] = 1'b1;
      if (acc) begin
        mValid = 1'b1; mRs1 = dec_rs1; mRs2 = dec_rs2; mRd = dec_rd; mWr = dec_wr_rd;
      end else if (iss_ready) begin
        mValid = 1'b0;
      end
    end
    #1;
    checkOutput({tag, ".iss_valid"}, {31'd0, iss_valid}, {31'd0, mValid});
    checkOutput({tag, ".pending"}, pending, pendVec());
    checkOutput({tag, ".inflight"}, {28'd0, inflight}, pendCount());
    if (mValid) begin
      checkOutput({tag, ".iss_rs1"}, {27'd0, iss_rs1}, {27'd0, mRs1});
      checkOutput({tag, ".iss_rs2"}, {27'd0, iss_rs2}, {27'd0, mRs2});
      checkOutput({tag, ".iss_rd"}, {27'd0, iss_rd}, {27'd0, mRd});
      checkOutput({tag, ".iss_wr_rd"}, {31'd0, iss_wr_rd}, {31'd0, mWr});
    end
    @(negedge clk);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    modelClear();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("reset.iss_valid", {31'd0, iss_valid}, 32'd0);
    checkOutput("reset.iss_rd", {27'd0, iss_rd}, 32'd0);
    checkOutput("reset.iss_rs1", {27'd0, iss_rs1}, 32'd0);
    checkOutput("reset.pending", pending, 32'd0);
    checkOutput("reset.inflight", {28'd0, inflight}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Independent stream: add x1,x2,x3 then add x4,x5,x6
    applyStimulus(1, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0); cycle("ind1", 1);
    applyStimulus(1, 5, 6, 4, 1, 1, 1, 1, 0, 0, 0); cycle("ind2", 1);
    checkOutput("ind.pendConst", pending, 32'h12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); cycle("ind.flush", 0);

    // RAW: lw x5, then add x7,x5 stalls until the cycle after wb x5
    applyStimulus(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 0); cycle("raw.lw", 1);
    applyStimulus(1, 5, 0, 7, 1, 0, 1, 1, 0, 0, 0); cycle("raw.stall1", 0);
    cycle("raw.stall2", 0);
    applyStimulus(1, 5, 0, 7, 1, 0, 1, 1, 1, 5, 0); cycle("raw.wbCycle", 0);
    applyStimulus(1, 5, 0, 7, 1, 0, 1, 1, 0, 0, 0); cycle("raw.accept", 1);
    checkOutput("raw.pendConst", pending, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); cycle("raw.flush", 0);

    // Back-pressure: FULL with iss_ready=0 for 3 cycles
    applyStimulus(1, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0); cycle("bp.fill", 1);
    applyStimulus(1, 8, 9, 0, 1, 1, 0, 0, 0, 0, 0); cycle("bp.hold1", 0);
    cycle("bp.hold2", 0);
    cycle("bp.hold3", 0);
    checkOutput("bp.heldRd", {27'd0, iss_rd}, 32'd1);
    applyStimulus(1, 8, 9, 0, 1, 1, 0, 1, 0, 0, 0); cycle("bp.release", 1);
    checkOutput("bp.newRs1", {27'd0, iss_rs1}, 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); cycle("bp.flush", 0);

    // Inflight limit with writers x1..x4
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, 0, 0, 5'(r), 0, 0, 1, 1, 0, 0, 0); cycle("lim.writer", 1);
    end
    checkOutput("lim.inflightConst", {28'd0, inflight}, 32'd4);
    applyStimulus(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0); cycle("lim.x7stall", 0);
    applyStimulus(1, 8, 9, 0, 1, 1, 0, 1, 0, 0, 0); cycle("lim.nonWriter", 1);
    applyStimulus(1, 0, 0, 7, 0, 0, 1, 1, 1, 2, 0); cycle("lim.wb2", 0);
    applyStimulus(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0); cycle("lim.x7accept", 1);
    checkOutput("lim.pendConst", pending, 32'h9A);

    // Simultaneous increment and decrement
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); cycle("sim.wb1");
    applyStimulus(1, 0, 0, 10, 0, 0, 1, 1, 1, 3, 0); cycle("sim.acceptX10", 1);
    checkOutput("sim.inflightConst", {28'd0, inflight}, 32'd3);
    checkOutput("sim.pendConst", pending, 32'h490);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); cycle("sim.flush", 0);

    // Flush with FULL and pending=0xF0 plus dec_valid
    for (int r = 4; r <= 7; r++) begin
      applyStimulus(1, 0, 0, 5'(r), 0, 0, 1, 0, 0, 0, 0);
      if (r == 4) cycle("fl.fill"); else applyStimulus(1, 0, 0, 5'(r), 0, 0, 1, 1, 0, 0, 0);
      if (r != 4) cycle("fl.fill");
    end
    checkOutput("fl.prePend", pending, 32'h0F0);
    applyStimulus(1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 1); cycle("fl.flush", 0);
    checkOutput("fl.validConst", {31'd0, iss_valid}, 32'd0);
    checkOutput("fl.pendConst", pending, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0); cycle("fl.wbIgnored");
    checkOutput("fl.inflightConst", {28'd0, inflight}, 32'd0);

    // Reset mid-operation
    applyStimulus(1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 0); cycle("rst.fill", 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst.iss_valid", {31'd0, iss_valid}, 32'd0);
    checkOutput("rst.pending", pending, 32'd0);
    checkOutput("rst.inflight", {28'd0, inflight}, 32'd0);
    modelClear();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                    $urandom_range(0, 24) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
